// File: rtl/alu_z_stage.sv
// alu_z_stage
// Result-capture stage behind the ALU. On an accepted z_in strobe it latches
// the ALU low/high results into the Z register pair (ZLO/ZHI) and the adder
// carry into carry_flag. DIV is decoded by the ALU but computed here by an
// iterative signed restoring divider (one quotient bit per cycle).
//
// Ports:
//   clk, clr        - rising-edge clock, asynchronous active-high reset
//   alu_instruc     - one-hot ALU select (bit0 AND ... bit5 DIV ... bit12 NOT)
//   alu_result      - ALU low result
//   alu_result_hi   - ALU high result (MUL only)
//   alu_carry       - ALU adder carry-out
//   operand_a/b     - dividend / divisor (same values the ALU sees)
//   z_in            - capture/start strobe; ignored while busy
//   zlo_out/zhi_out - Z register pair
//   carry_flag      - carry captured on the last ADD/SUB
//   busy            - divider active
//   done            - one-cycle pulse after the Z registers were written
//   div_by_zero     - sticky; set by DIV with operand_b==0, cleared by next accepted z_in
module alu_z_stage #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [12:0]      alu_instruc,
  input  logic [WIDTH-1:0] alu_result,
  input  logic [WIDTH-1:0] alu_result_hi,
  input  logic             alu_carry,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             z_in,
  output logic [WIDTH-1:0] zlo_out,
  output logic [WIDTH-1:0] zhi_out,
  output logic             carry_flag,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int CNT_W  = $clog2(WIDTH) + 1;
  localparam int OP_ADD = 2;
  localparam int OP_SUB = 3;
  localparam int OP_MUL = 4;
  localparam int OP_DIV = 5;

  typedef enum logic [1:0] {IDLE, DIV_RUN, DIV_FIX} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rem, quo, dvs;
  logic             q_neg, r_neg, dbz_pend;

  logic             accept, is_onehot, is_div, step_ok;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] rem_sh;

  // Magnitude of a signed value; the most-negative value maps to its own
  // unsigned pattern, which is exactly the magnitude in WIDTH unsigned bits.
  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // Two's-complement negate when s is set (wraps for the most-negative value).
  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] v,
                                                  input logic s);
    return s ? ((~v) + WIDTH'(1)) : v;
  endfunction

  assign accept    = (state == IDLE) && z_in;
  assign is_onehot = (alu_instruc != '0) &&
                     ((alu_instruc & (alu_instruc - 13'd1)) == '0);
  assign is_div    = is_onehot && alu_instruc[OP_DIV];
  assign busy      = (state != IDLE);

  // Restoring step: shift {rem,quo} left and trial-subtract the divisor with
  // one extra bit so the bit shifted out of rem is not lost.
  assign rem_sh  = {rem[WIDTH-2:0], quo[WIDTH-1]};
  assign trial   = {rem, quo[WIDTH-1]} - {1'b0, dvs};
  assign step_ok = ~trial[WIDTH];

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && is_div)
                 state_nxt = (operand_b == '0) ? DIV_FIX : DIV_RUN;
      // cnt==1 here means this is the last of the WIDTH steps.
      DIV_RUN: if (cnt == CNT_W'(1)) state_nxt = DIV_FIX;
      DIV_FIX: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      zlo_out     <= '0;
      zhi_out     <= '0;
      carry_flag  <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      cnt         <= '0;
      rem         <= '0;
      quo         <= '0;
      dvs         <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dbz_pend    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            div_by_zero <= 1'b0;
            if (is_div) begin
              if (operand_b == '0) begin
                // Preload so DIV_FIX emits all-ones / raw dividend unsigned.
                rem      <= operand_a;
                quo      <= '1;
                dvs      <= '0;
                q_neg    <= 1'b0;
                r_neg    <= 1'b0;
                dbz_pend <= 1'b1;
                cnt      <= '0;
              end else begin
                rem      <= '0;
                quo      <= mag(operand_a);
                dvs      <= mag(operand_b);
                q_neg    <= operand_a[WIDTH-1] ^ operand_b[WIDTH-1];
                r_neg    <= operand_a[WIDTH-1];
                dbz_pend <= 1'b0;
                cnt      <= CNT_W'(WIDTH);
              end
            end else if (is_onehot) begin
              zlo_out <= alu_result;
              zhi_out <= alu_instruc[OP_MUL] ? alu_result_hi : '0;
              if (alu_instruc[OP_ADD] || alu_instruc[OP_SUB])
                carry_flag <= alu_carry;
              done <= 1'b1;
            end else begin
              // Illegal select: clear Z but still acknowledge the strobe.
              zlo_out <= '0;
              zhi_out <= '0;
              done    <= 1'b1;
            end
          end
        end
        DIV_RUN: begin
          rem <= step_ok ? trial[WIDTH-1:0] : rem_sh;
          quo <= {quo[WIDTH-2:0], step_ok};
          cnt <= cnt - CNT_W'(1);
        end
        DIV_FIX: begin
          zlo_out     <= apply_sign(quo, q_neg);
          zhi_out     <= apply_sign(rem, r_neg);
          div_by_zero <= dbz_pend;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_z_stage.sv
// Directed testbench for alu_z_stage: captures, signed divides, corner cases,
// ignored strobe while busy and asynchronous abort.
module tb_alu_z_stage;
  localparam int W = 32;
  localparam logic [12:0] OP_AND = 13'h0001;
  localparam logic [12:0] OP_ADD = 13'h0004;
  localparam logic [12:0] OP_SUB = 13'h0008;
  localparam logic [12:0] OP_MUL = 13'h0010;
  localparam logic [12:0] OP_DIV = 13'h0020;

  logic         clk = 1'b0;
  logic         clr;
  logic [12:0]  instr;
  logic [W-1:0] res, res_hi, opa, opb;
  logic         carry_in, z_in;
  logic [W-1:0] zlo, zhi;
  logic         carry_flag, busy, done, dbz;

  int n_vec = 0;
  int n_err = 0;

  alu_z_stage #(.WIDTH(W)) dut (
    .clk(clk), .clr(clr), .alu_instruc(instr), .alu_result(res),
    .alu_result_hi(res_hi), .alu_carry(carry_in), .operand_a(opa),
    .operand_b(opb), .z_in(z_in), .zlo_out(zlo), .zhi_out(zhi),
    .carry_flag(carry_flag), .busy(busy), .done(done), .div_by_zero(dbz)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic capture(input string tag, input logic [12:0] op,
                         input logic [W-1:0] r, input logic [W-1:0] h,
                         input logic c, input logic [W-1:0] ezlo,
                         input logic [W-1:0] ezhi, input logic ecarry);
    instr = op; res = r; res_hi = h; carry_in = c; z_in = 1'b1;
    tick();
    z_in = 1'b0;
    chk({tag, " zlo"}, zlo, ezlo);
    chk({tag, " zhi"}, zhi, ezhi);
    chk({tag, " carry"}, carry_flag, ecarry);
    chk({tag, " done"}, done, 1'b1);
    tick();
    chk({tag, " done_fall"}, done, 1'b0);
  endtask

  // inj > 0 pulses an ADD capture strobe on that busy cycle.
  task automatic run_div(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] eq,
                         input logic [W-1:0] er, input int ecyc,
                         input logic edbz, input int inj);
    int   cyc;
    logic overlap;
    instr = OP_DIV; opa = a; opb = b; z_in = 1'b1;
    tick();
    z_in = 1'b0;
    cyc = 0;
    overlap = 1'b0;
    while (busy && cyc < 100) begin
      cyc++;
      if (done) overlap = 1'b1;
      if (cyc == inj) begin
        instr = OP_ADD; res = 32'hDEADBEEF; carry_in = ~carry_flag;
        opa = '0; opb = '0; z_in = 1'b1;
      end
      tick();
      z_in = 1'b0;
    end
    chk({tag, " busy_len"}, cyc, ecyc);
    chk({tag, " busy_done_overlap"}, overlap, 1'b0);
    chk({tag, " done"}, done, 1'b1);
    chk({tag, " quo"}, zlo, eq);
    chk({tag, " rem"}, zhi, er);
    chk({tag, " dbz"}, dbz, edbz);
    tick();
    chk({tag, " done_fall"}, done, 1'b0);
    chk({tag, " zlo_hold"}, zlo, eq);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic stray;
    clr = 1'b1; instr = '0; res = '0; res_hi = '0; opa = '0; opb = '0;
    carry_in = 1'b0; z_in = 1'b0;
    #3;
    chk("rst zlo", zlo, '0);
    chk("rst zhi", zhi, '0);
    chk("rst carry", carry_flag, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst dbz", dbz, 1'b0);
    tick();
    clr = 1'b0;
    tick();

    capture("add", OP_ADD, 32'h00000005, 32'h0, 1'b1, 32'h5, 32'h0, 1'b1);
    capture("mul", OP_MUL, 32'h89ABCDEF, 32'h01234567, 1'b0,
            32'h89ABCDEF, 32'h01234567, 1'b1);
    capture("and", OP_AND, 32'h0F0F0F0F, 32'hFFFFFFFF, 1'b0,
            32'h0F0F0F0F, 32'h0, 1'b1);
    capture("multihot", OP_ADD | OP_SUB, 32'h1234, 32'h5678, 1'b0,
            32'h0, 32'h0, 1'b1);
    capture("sub", OP_SUB, 32'h00000003, 32'hAAAA, 1'b0, 32'h3, 32'h0, 1'b0);

    run_div("div -7/2", 32'hFFFFFFF9, 32'h2, 32'hFFFFFFFD, 32'hFFFFFFFF, 33, 1'b0, 0);
    run_div("div 100/7", 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 0);
    run_div("div 7/-2", 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 33, 1'b0, 0);
    run_div("div min/-1", 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0, 33, 1'b0, 0);
    run_div("div 5/0", 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1, 1'b1, 0);
    capture("and after dbz", OP_AND, 32'h11, 32'h0, 1'b0, 32'h11, 32'h0, 1'b0);
    chk("dbz cleared", dbz, 1'b0);

    run_div("div ignored strobe", 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 10);
    chk("carry after ignored strobe", carry_flag, 1'b0);

    // Abort a divide with an asynchronous clr in the middle of a cycle.
    instr = OP_DIV; opa = 32'hFFFFFFF9; opb = 32'h2; z_in = 1'b1;
    tick();
    z_in = 1'b0;
    repeat (14) tick();
    #2 clr = 1'b1;
    #1;
    chk("abort busy", busy, 1'b0);
    chk("abort zlo", zlo, '0);
    chk("abort zhi", zhi, '0);
    chk("abort done", done, 1'b0);
    chk("abort carry", carry_flag, 1'b0);
    chk("abort dbz", dbz, 1'b0);
    #1 clr = 1'b0;
    stray = 1'b0;
    repeat (40) begin
      tick();
      if (done || busy) stray = 1'b1;
    end
    chk("abort no done", stray, 1'b0);
    run_div("div after abort", 32'd100, 32'd7, 32'd14, 32'd2, 33, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
